// File: rtl/pipelined_alu_acc.sv
// pipelined_alu_acc: stallable LATENCY-deep ADD/SUB/OR/ACC pipeline with valid/ready handshakes and sticky accumulator wrap flag
module pipelined_alu_acc #(
  parameter int WIDTH = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic [1:0]       out_op,
  output logic             acc_ovf
);
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0][WIDTH:0] dat_q, dat_d;
  logic [LATENCY-1:0][1:0] op_q, op_d;
  logic [WIDTH:0] acc_q, acc_d, acc_base, res;
  logic [WIDTH+1:0] acc_sum;
  logic acc_ovf_q, acc_ovf_d, adv, acc_fire;
  always_comb begin
    adv = !vld_q[LATENCY-1] || out_ready;
    acc_fire = in_valid && adv && op == 2'b11;
    acc_base = clr_acc ? '0 : acc_q;
    acc_sum = {1'b0, acc_base} + {2'b00, in1};
    res = op == 2'b00 ? {1'b0, in1} + {1'b0, in2} :
          op == 2'b01 ? {1'b0, in1} - {1'b0, in2} :
          op == 2'b10 ? {1'b0, in1 | in2} : acc_sum[WIDTH:0];
    vld_d = vld_q;
    dat_d = dat_q;
    op_d = op_q;
    if (adv) begin
      vld_d[0] = in_valid;
      dat_d[0] = res;
      op_d[0] = op;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
        op_d[i] = op_q[i-1];
      end
    end
    acc_d = acc_fire ? acc_sum[WIDTH:0] : acc_base;
    acc_ovf_d = (!clr_acc && acc_ovf_q) || (acc_fire && acc_sum[WIDTH+1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
      op_q <= '0;
      acc_q <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      op_q <= op_d;
      acc_q <= acc_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end
  assign in_ready = adv;
  assign out_valid = vld_q[LATENCY-1];
  assign out_data = dat_q[LATENCY-1];
  assign out_op = op_q[LATENCY-1];
  assign acc_ovf = acc_ovf_q;
endmodule

// File: doc/pipelined_alu_acc.md
Name: pipelined_alu_acc

Overview:
Parametrised successor to the single-cycle 8-bit adder/OR block. It issues one operation per accepted transaction: add, subtract, bitwise OR, or running accumulate. Results pass through a LATENCY-deep stallable pipeline with valid/ready handshakes on input and output. It sits between operand producers and downstream consumers that may apply backpressure.

Parameters:
WIDTH, 8, operand width in bits (>=2).
LATENCY, 2, pipeline depth in register stages from acceptance to out_valid (1..4).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/op valid.
in_ready  output  1  block can accept this cycle.
op  input  2  00 ADD, 01 SUB, 10 OR, 11 ACC.
in1  input  WIDTH  first operand.
in2  input  WIDTH  second operand (ignored for ACC).
clr_acc  input  1  clear accumulator.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  WIDTH+1  result.
out_op  output  2  op that produced out_data.
acc_ovf  output  1  sticky accumulator wrap flag.

Behaviour:
- Reset (rst high at an edge): all pipeline valid bits 0, out_valid=0, out_data=0, out_op=0, accumulator=0, acc_ovf=0. rst overrides every other input in the same cycle. In-flight results are discarded.
- Accept: transaction taken at an edge when in_valid && in_ready.
- Stall: advance = !out_valid || out_ready. When advance=0, every stage holds. in_ready = advance, combinational, with no bubble-collapsing. A full pipeline with out_ready=1 sustains 1 op/cycle.
- Latency: a result accepted at edge k is presented with out_valid=1 after edge k+LATENCY-1, plus any stall cycles. LATENCY=1 means the result is valid in the cycle after acceptance. Order is strictly preserved.
- out_data, out_valid and out_op hold stable while out_valid && !out_ready.
- Arithmetic (computed in stage 1 and carried through the remaining stages):
  - ADD: {1'b0,in1} + {1'b0,in2}, WIDTH+1 bits with carry in the MSB.
  - SUB: {1'b0,in1} - {1'b0,in2}, modulo 2^(WIDTH+1). The MSB is the borrow (1 when in1<in2).
  - OR: {1'b0, in1|in2}.
  - ACC: acc_next = acc + {1'b0,in1}, modulo 2^(WIDTH+1). out_data = acc_next. The accumulator updates at acceptance, not at output.
  - acc_ovf sets when the ACC addition carries out of bit WIDTH. It clears only on rst or clr_acc.
- clr_acc without an accepted ACC: accumulator=0 and acc_ovf=0 at the edge.
- clr_acc with an accepted ACC in the same cycle: the clear applies first, so acc_next = {1'b0,in1}, out_data = in1, and acc_ovf=0.
- clr_acc with an accepted non-ACC op: the clear applies and the op proceeds normally.
- clr_acc acts whether or not the pipeline is stalled. It does not alter results already in flight.
- op, in1, in2 and clr_acc are don't-care for datapath purposes when in_valid=0, except that clr_acc still clears.
- An ACC presented while in_ready=0 is not accepted and the accumulator is unchanged.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, acc_ovf=0, and no result appears afterwards.
2. ADD/SUB/OR (WIDTH=8, LATENCY=2, out_ready=1): issue back-to-back 200+100, 5-10, 0xA5|0x0F. Expect out_valid on 3 consecutive cycles from the cycle after edge k+1, with out_data 0x12C, 0x1FB, 0x0AF and out_op 00/01/10.
3. Backpressure: stream 6 ADDs with out_ready=0 for 4 cycles mid-stream. Expect in_ready=0 while stalled with a valid result held, out_data stable while out_valid && !out_ready, all 6 results delivered in order, no duplicates.
4. Accumulate: clr_acc, then ACC 255, 255, 3. Expect out_data 0x0FF, 0x1FE, 0x001, with acc_ovf rising on the third op and staying 1.
5. Clear interactions:
   - clr_acc alone -> acc_ovf=0.
   - ACC 7 with clr_acc in the same cycle -> out_data 0x007.
   - Then ACC 1 -> 0x008.
6. Reset mid-operation: rst asserted with 2 results in flight and out_ready=0. Expect out_valid=0 the next cycle, accumulator 0, and a subsequent ACC 4 giving 0x004.
